// File: rtl/ram_master_pkg.sv
// Shared types and constants for the RAM bus master.
package ram_master_pkg;

    localparam int unsigned WIDTH_DEF   = 16;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned ADDRESS_DEF = 3;

    // Access counter holds ACC_CYCLES-1, so 4 bits cover the 1..15 range.
    localparam int unsigned ACC_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_e;

    // Counter reload value for a strobe lasting acc cycles.
    function automatic logic [ACC_CNT_W-1:0] acc_load(input int unsigned acc);
        return ACC_CNT_W'(acc - 1);
    endfunction

endpackage

// File: rtl/ram_acc_timer.sv
// Loadable down-counter timing the ACCESS phase; zero_c flags the last cycle.
module ram_acc_timer
    import ram_master_pkg::*;
#(
    parameter int unsigned ACC_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_c
);

    logic [ACC_CNT_W-1:0] cnt_q;
    logic [ACC_CNT_W-1:0] cnt_d;

    // Reload on entry to ACCESS, count down while the strobe is held.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = acc_load(ACC_CYCLES);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ACC_CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/ram_bus_master.sv
// Initiator for an async single-port RAM: sequences addr/we/re and the shared
// data bus through SETUP/ACCESS/HOLD for one host command at a time.
// Optional: RAM_MASTER_RANGE_CHECK_EN adds rsp_err and rejects addr >= DEPTH.
module ram_bus_master
    import ram_master_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned ADDRESS    = ADDRESS_DEF,
    parameter int unsigned ACC_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_we,
    input  logic [ADDRESS-1:0] cmd_addr,
    input  logic [WIDTH-1:0]   cmd_wdata,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_rdata,
`ifdef RAM_MASTER_RANGE_CHECK_EN
    output logic               rsp_err,
`endif
    output logic [ADDRESS-1:0] ram_addr,
    output logic               ram_we,
    output logic               ram_re,
    inout  wire  [WIDTH-1:0]   ram_data
);

`ifdef RAM_MASTER_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    state_e             state_q, state_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDRESS-1:0] ram_addr_q, ram_addr_d;
    logic               ram_we_q, ram_we_d;
    logic               ram_re_q, ram_re_d;
    logic               drive_q, drive_d;
    logic               we_q, we_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;

    logic               accept_c;
    logic               range_err_c;
    logic               tmr_load_c;
    logic               tmr_dec_c;
    logic               tmr_zero_c;

    assign accept_c    = (state_q == IDLE) && cmd_valid && cmd_ready_q;
    assign range_err_c = RANGE_CHECK && (32'(cmd_addr) >= DEPTH);

    ram_acc_timer #(
        .ACC_CYCLES (ACC_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (tmr_load_c),
        .dec_i  (tmr_dec_c),
        .zero_c (tmr_zero_c)
    );

    // Next state plus next value of every registered output.
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        drive_d     = 1'b0;
        we_d        = we_q;
        wdata_d     = wdata_q;
        tmr_load_c  = 1'b0;
        tmr_dec_c   = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (accept_c) begin
                    cmd_ready_d = 1'b0;
                    we_d        = cmd_we;
                    wdata_d     = cmd_wdata;
                    if (range_err_c) begin
                        // Rejected address: straight to the response, no strobes.
                        state_d     = HOLD;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d    = SETUP;
                        ram_addr_d = cmd_addr;
                        drive_d    = cmd_we;
                    end
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                tmr_load_c = 1'b1;
                ram_we_d   = we_q;
                ram_re_d   = !we_q;
                drive_d    = we_q;
            end
            ACCESS: begin
                drive_d = we_q;
                if (tmr_zero_c) begin
                    state_d     = HOLD;
                    rsp_valid_d = 1'b1;
                    if (!we_q) begin
                        rsp_rdata_d = ram_data;
                    end
                end else begin
                    tmr_dec_c = 1'b1;
                    ram_we_d  = we_q;
                    ram_re_d  = !we_q;
                end
            end
            HOLD: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            drive_q     <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            drive_q     <= drive_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
        end
    end

`ifdef RAM_MASTER_RANGE_CHECK_EN
    logic rsp_err_q, rsp_err_d;

    // Error flag is high only during the HOLD cycle of a rejected command.
    always_comb begin
        rsp_err_d = accept_c && range_err_c;
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`endif

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_re    = ram_re_q;

    // Bus driven only from registered enable and data.
    assign ram_data = drive_q ? wdata_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_bus_master.sv
// Self-checking bench for ram_bus_master with a behavioural async RAM.
`timescale 1ns/1ps
module tb_ram_bus_master;

    localparam int unsigned W   = 16;
    localparam int unsigned AW  = 3;
    localparam int unsigned ACC = 2;
`ifdef RAM_MASTER_RANGE_CHECK_EN
    localparam int unsigned DEP = 6;
`else
    localparam int unsigned DEP = 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cmd_valid, cmd_ready, cmd_we, rsp_valid, ram_we, ram_re;
    logic [AW-1:0] cmd_addr, ram_addr;
    logic [W-1:0]  cmd_wdata, rsp_rdata;
    logic          rsp_err;
    wire  [W-1:0]  ram_data;

    // Async RAM model: drives the bus while re is high, captures while we is high.
    logic [W-1:0] ram_mem [8];
    assign ram_data = (ram_re && !ram_we) ? ram_mem[ram_addr] : {W{1'bz}};
    always @(negedge clk) if (ram_we) ram_mem[ram_addr] <= ram_data;

    ram_bus_master #(
        .WIDTH(W), .DEPTH(DEP), .ADDRESS(AW), .ACC_CYCLES(ACC)
    ) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef RAM_MASTER_RANGE_CHECK_EN
        .rsp_err(rsp_err),
`endif
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re), .ram_data(ram_data)
    );
`ifndef RAM_MASTER_RANGE_CHECK_EN
    assign rsp_err = 1'b0;
`endif

    int nvec = 0;
    int nfail = 0;
    int overlap_cnt = 0;
    int rsp_cnt = 0;
    always @(negedge clk) begin
        if (ram_we && ram_re) overlap_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: RAM contents and last returned read data.
    logic [W-1:0] model_mem [8];
    logic [W-1:0] last_rd;

    function automatic logic is_oob(input logic [AW-1:0] a);
`ifdef RAM_MASTER_RANGE_CHECK_EN
        return 32'(a) >= DEP;
`else
        return (a != a);
`endif
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One command with full phase checking against the reference rules.
    task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                          input logic [W-1:0] exp_rd);
        bit ok;
        int lat, sw, xw, bus_bad, addr_bad, exp_lat, exp_sw;
        logic [AW-1:0] addr0;
        logic [W-1:0] rd_seen;
        logic err_seen, oob, after;
        oob = is_oob(addr);
        lat = 0; sw = 0; xw = 0; bus_bad = 0; addr_bad = 0;
        rd_seen = '0; err_seen = 1'b0;
        wait_ready(ok);
        if (!ok) chk("ready_timeout", 0, 1);
        addr0 = ram_addr;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = W'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (we ? ram_we : ram_re) sw++;
            if (we ? ram_re : ram_we) xw++;
            if (oob) begin
                if (ram_addr !== addr0) addr_bad++;
            end else begin
                if (ram_addr !== addr) addr_bad++;
                if (we && ram_data !== wd) bus_bad++;
                if (!we && ram_re && ram_data !== exp_rd) bus_bad++;
            end
            if (rsp_valid) begin
                lat = k;
                rd_seen = rsp_rdata;
                err_seen = rsp_err;
                break;
            end
        end
        @(negedge clk);
        after = rsp_valid;
        exp_lat = oob ? 1 : ACC + 2;
        exp_sw  = oob ? 0 : ACC;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("strobe_width", 32'(sw), 32'(exp_sw));
        chk("wrong_strobe", 32'(xw), 0);
        chk("ram_addr", 32'(addr_bad), 0);
        chk("bus_value", 32'(bus_bad), 0);
        chk("rsp_rdata", 32'(rd_seen), 32'(exp_rd));
        chk("rsp_one_cycle", 32'(after), 0);
`ifdef RAM_MASTER_RANGE_CHECK_EN
        chk("rsp_err", 32'(err_seen), 32'(oob));
`endif
        if (!oob) begin
            if (we) model_mem[addr] = wd;
            else    last_rd = exp_rd;
        end
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        logic [W-1:0]  exp_rdata;
    } vec_t;
    vec_t tbl [18];

    // Secondary instances exercising the extreme access lengths.
    for (genvar gi = 0; gi < 2; gi++) begin : g_x
        localparam int unsigned A = (gi == 0) ? 1 : 15;
        logic          x_rst, x_valid, x_ready, x_we, x_rsp, x_rwe, x_rre;
        logic [AW-1:0] x_addr, x_raddr;
        logic [W-1:0]  x_wd, x_rd;
        wire  [W-1:0]  x_bus;
        logic [W-1:0]  x_mem [8];
`ifdef RAM_MASTER_RANGE_CHECK_EN
        logic          x_err;
`endif
        int            we_w, re_w, wlat, rlat;
        logic [W-1:0]  rd_got;
        bit            done;

        assign x_bus = (x_rre && !x_rwe) ? x_mem[x_raddr] : {W{1'bz}};
        always @(negedge clk) if (x_rwe) x_mem[x_raddr] <= x_bus;

        ram_bus_master #(
            .WIDTH(W), .DEPTH(8), .ADDRESS(AW), .ACC_CYCLES(A)
        ) u_x (
            .clk(clk), .rst(x_rst),
            .cmd_valid(x_valid), .cmd_ready(x_ready), .cmd_we(x_we),
            .cmd_addr(x_addr), .cmd_wdata(x_wd),
            .rsp_valid(x_rsp), .rsp_rdata(x_rd),
`ifdef RAM_MASTER_RANGE_CHECK_EN
            .rsp_err(x_err),
`endif
            .ram_addr(x_raddr), .ram_we(x_rwe), .ram_re(x_rre), .ram_data(x_bus)
        );

        initial begin : x_seq
            int n;
            int lat;
            done = 1'b0; we_w = 0; re_w = 0; wlat = 0; rlat = 0; rd_got = '0;
            x_rst = 1'b1; x_valid = 1'b0; x_we = 1'b0; x_addr = '0; x_wd = '0;
            repeat (2) @(posedge clk);
            #1 x_rst = 1'b0;
            for (int op = 0; op < 2; op++) begin
                n = 0; lat = 0;
                for (int i = 0; i < 64; i++) begin
                    @(negedge clk);
                    if (x_ready) break;
                end
                x_valid = 1'b1; x_we = (op == 0); x_addr = 3'd2; x_wd = 16'h5A3C;
                @(posedge clk);
                #1 x_valid = 1'b0; x_wd = 16'h0000;
                for (int k = 1; k <= 60; k++) begin
                    @(negedge clk);
                    if (op == 0 ? x_rwe : x_rre) n++;
                    if (x_rsp) begin
                        lat = k;
                        if (op == 1) rd_got = x_rd;
                        break;
                    end
                end
                if (op == 0) begin we_w = n; wlat = lat; end
                else         begin re_w = n; rlat = lat; end
            end
            done = 1'b1;
        end
    end

    initial begin : main
        logic [W-1:0] lr, exp_rd;
        logic [AW-1:0] bb_addr [3];
        logic [W-1:0]  bb_data [3];
        int acc_cyc [3];
        int nacc, cyc, rsp0, nrsp, nwe;
        bit ok;
        logic rnd_we;
        logic [AW-1:0] rnd_addr;
        logic [W-1:0] rnd_wd;

        // Table: single write, read-back, sweep writes, sweep reads.
        lr = '0;
        tbl[0] = '{1'b1, 3'd3, 16'hA5A5, lr};
        lr = is_oob(3'd3) ? lr : 16'hA5A5;
        tbl[1] = '{1'b0, 3'd3, 16'h0000, lr};
        for (int i = 0; i < 8; i++) tbl[2 + i] = '{1'b1, AW'(i), W'(i * 16'h1111), lr};
        for (int i = 0; i < 8; i++) begin
            if (!is_oob(AW'(i))) lr = W'(i * 16'h1111);
            tbl[10 + i] = '{1'b0, AW'(i), 16'h0000, lr};
        end

        // Reset state.
        rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_re", 32'(ram_re), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset asserted for two cycles while a write is in ACCESS.
        wait_ready(ok);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 3'd5; cmd_wdata = 16'hBEEF;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        nwe = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ram_we) begin nwe = 1; break; end
        end
        chk("midrst_reached_access", 32'(nwe), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ram_we", 32'(ram_we), 0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        rsp0 = rsp_cnt;
        repeat (8) @(negedge clk);
        chk("midrst_no_response", 32'(rsp_cnt - rsp0), 0);
        chk("midrst_rsp_rdata", 32'(rsp_rdata), 0);
        last_rd = '0;

        // Table-driven vectors.
        for (int i = 0; i < 18; i++) begin
            do_cmd(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
            chk("tbl_model_rdata", 32'(last_rd), 32'(tbl[i].exp_rdata));
        end

        // Back-to-back: cmd_valid held high across three writes.
        bb_addr[0] = 3'd1; bb_addr[1] = 3'd2; bb_addr[2] = 3'd4;
        for (int i = 0; i < 3; i++) bb_data[i] = W'($urandom);
        wait_ready(ok);
        rsp0 = rsp_cnt;
        nacc = 0; cyc = 0;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = bb_addr[0]; cmd_wdata = bb_data[0];
        for (int c = 0; c < 100 && nacc < 3; c++) begin
            if (c > 0) @(negedge clk);
            cyc++;
            if (cmd_ready) begin
                acc_cyc[nacc] = cyc;
                @(posedge clk);
                #1;
                nacc++;
                if (nacc < 3) begin
                    cmd_addr = bb_addr[nacc]; cmd_wdata = bb_data[nacc];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        repeat (ACC + 4) @(negedge clk);
        chk("b2b_accepts", 32'(nacc), 3);
        chk("b2b_gap0", 32'(acc_cyc[1] - acc_cyc[0]), ACC + 3);
        chk("b2b_gap1", 32'(acc_cyc[2] - acc_cyc[1]), ACC + 3);
        chk("b2b_responses", 32'(rsp_cnt - rsp0), 3);
        for (int i = 0; i < 3; i++) model_mem[bb_addr[i]] = bb_data[i];
        for (int i = 0; i < 3; i++) do_cmd(1'b0, bb_addr[i], 16'h0000, model_mem[bb_addr[i]]);

        // Randomized commands against the reference model.
        for (int i = 0; i < 30; i++) begin
            rnd_we = 1'($urandom);
            rnd_addr = AW'($urandom_range(0, 7));
            rnd_wd = W'($urandom);
            exp_rd = (!rnd_we && !is_oob(rnd_addr)) ? model_mem[rnd_addr] : last_rd;
            do_cmd(rnd_we, rnd_addr, rnd_wd, exp_rd);
        end

        chk("we_re_overlap", 32'(overlap_cnt), 0);

        // Extreme access lengths.
        for (int i = 0; i < 800 && !(g_x[0].done && g_x[1].done); i++) @(negedge clk);
        chk("acc1_we_width", 32'(g_x[0].we_w), 1);
        chk("acc1_wr_latency", 32'(g_x[0].wlat), 3);
        chk("acc1_re_width", 32'(g_x[0].re_w), 1);
        chk("acc1_rd_latency", 32'(g_x[0].rlat), 3);
        chk("acc1_rdata", 32'(g_x[0].rd_got), 32'h5A3C);
        chk("acc15_we_width", 32'(g_x[1].we_w), 15);
        chk("acc15_wr_latency", 32'(g_x[1].wlat), 17);
        chk("acc15_re_width", 32'(g_x[1].re_w), 15);
        chk("acc15_rd_latency", 32'(g_x[1].rlat), 17);
        chk("acc15_rdata", 32'(g_x[1].rd_got), 32'h5A3C);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
